// File: rtl/reverse_mix_cols.sv
`default_nettype none
// ============================================================================
// Module   : reverse_mix_cols
// Brief    : AES InvMixColumns on one 32-bit column, one result register,
//            1-cycle latency, one column per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reverse_mix_cols (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] input_col,
  output logic [31:0] final_col,
  output logic        out_valid
);

  localparam logic [7:0] c_reduce = 8'h1b;

  logic [31:0] r_final_col;
  logic        r_out_valid;
  logic [31:0] w_result;
  logic [7:0]  w_a0, w_a1, w_a2, w_a3;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? c_reduce : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  assign w_a0 = input_col[31:24];
  assign w_a1 = input_col[23:16];
  assign w_a2 = input_col[15:8];
  assign w_a3 = input_col[7:0];

  // Circulant rows of the inverse matrix {0E,0B,0D,09}
  always_comb begin
    w_result = 32'h0000_0000;
    w_result[31:24] = mul0e(w_a0) ^ mul0b(w_a1) ^ mul0d(w_a2) ^ mul09(w_a3);
    w_result[23:16] = mul09(w_a0) ^ mul0e(w_a1) ^ mul0b(w_a2) ^ mul0d(w_a3);
    w_result[15:8]  = mul0d(w_a0) ^ mul09(w_a1) ^ mul0e(w_a2) ^ mul0b(w_a3);
    w_result[7:0]   = mul0b(w_a0) ^ mul0d(w_a1) ^ mul09(w_a2) ^ mul0e(w_a3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_final_col <= 32'h0000_0000;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_final_col <= w_result;
      end
    end
  end

  assign final_col = r_final_col;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_reverse_mix_cols.sv
`default_nettype none
// ============================================================================
// Module   : tb_reverse_mix_cols
// Brief    : Directed vectors plus a forward-MixColumns round-trip check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reverse_mix_cols;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] input_col;
  logic [31:0] final_col;
  logic        out_valid;

  int checks;
  int errors;

  reverse_mix_cols dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .input_col (input_col),
    .final_col (final_col),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] x);
    return m2(x) ^ x;
  endfunction

  // Forward MixColumns, used to undo the DUT's inverse transform
  function automatic logic [31:0] fwd_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {m2(a0) ^ m3(a1) ^ a2 ^ a3,
            a0 ^ m2(a1) ^ m3(a2) ^ a3,
            a0 ^ a1 ^ m2(a2) ^ m3(a3),
            m3(a0) ^ a1 ^ a2 ^ m2(a3)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a column, let one rising edge pass, return 1 time unit after it
  task automatic step(input logic v, input logic [31:0] c);
    in_valid  = v;
    input_col = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] col;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    input_col = 32'h0;

    #2;
    check("reset_col", final_col, 32'h0);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    step(1'b1, 32'h416e1899);
    check("vec1_col", final_col, 32'hc9dad76a);
    check("vec1_valid", {31'h0, out_valid}, 32'h1);

    step(1'b1, 32'he0958b65);
    check("vec2_col", final_col, 32'h926bd4b6);

    step(1'b1, 32'h8e4da1bc);
    check("b2b0_col", final_col, 32'hdb135345);
    check("b2b0_valid", {31'h0, out_valid}, 32'h1);
    step(1'b1, 32'h01010101);
    check("b2b1_col", final_col, 32'h01010101);
    check("b2b1_valid", {31'h0, out_valid}, 32'h1);
    step(1'b1, 32'hc6c6c6c6);
    check("b2b2_col", final_col, 32'hc6c6c6c6);
    check("b2b2_valid", {31'h0, out_valid}, 32'h1);

    step(1'b1, 32'h00000000);
    check("zero_col", final_col, 32'h0);
    check("zero_valid", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'hdeadbeef);
      check("idle_hold", final_col, 32'h0);
      check("idle_valid", {31'h0, out_valid}, 32'h0);
    end

    step(1'b1, 32'h416e1899);
    check("reload_col", final_col, 32'hc9dad76a);
    step(1'b0, 32'h12345678);
    check("hold_nonzero", final_col, 32'hc9dad76a);
    check("hold_valid", {31'h0, out_valid}, 32'h0);

    step(1'b1, 32'h416e1899);
    check("pre_async", final_col, 32'hc9dad76a);
    #2;
    reset     = 1'b1;
    in_valid  = 1'b1;
    input_col = 32'he0958b65;
    #1;
    check("async_col", final_col, 32'h0);
    check("async_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("discard_col", final_col, 32'h0);
    check("discard_valid", {31'h0, out_valid}, 32'h0);
    reset = 1'b0;
    step(1'b1, 32'he0958b65);
    check("post_reset_col", final_col, 32'h926bd4b6);
    check("post_reset_valid", {31'h0, out_valid}, 32'h1);

    for (int i = 0; i < 24; i++) begin
      col = $urandom;
      step(1'b1, col);
      check("roundtrip", fwd_mix(final_col), col);
      check("roundtrip_valid", {31'h0, out_valid}, 32'h1);
    end
    step(1'b0, 32'h0);
    check("final_idle_valid", {31'h0, out_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
